// File: rtl/tristate_bus_reader_pkg.sv
// Shared types, constants and helpers for the tri-state bus reader.
// The reader drives one active-low chip select at a time onto a shared
// register bus, so the helpers here build those select patterns.
package tristate_bus_reader_pkg;

    // Reader sequencing: wait for a request, hold a source selected while
    // the bus settles, then present the captured value until it is taken.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SELECT  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    // Widest supported source count; narrower readers slice this down.
    localparam int MAX_SOURCES = 16;

    // Every source floating: no chip select asserted.
    localparam logic [MAX_SOURCES-1:0] CS_IDLE = '1;

    // Active-low one-hot select for a single source index.
    function automatic logic [MAX_SOURCES-1:0] cs_one_hot_low(input logic [3:0] index);
        logic [MAX_SOURCES-1:0] result;
        result        = CS_IDLE;
        result[index] = 1'b0;
        return result;
    endfunction

endpackage

// File: rtl/tristate_bus_reader_settle.sv
// Settle counter for the tri-state bus reader.
// Counts qualified ticks while a source is selected so the captured value
// is only taken once the shared bus has had time to settle.
module settle_tick_counter (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       adv,
    input  logic       load,
    input  logic       dec,
    input  logic [3:0] load_value,
    output logic       zero
);

    logic [3:0] count;

    // Load takes priority over decrement; both only act on a qualified tick,
    // and the counter rests at zero rather than wrapping.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count <= 4'd0;
        end else if (adv) begin
            if (load) begin
                count <= load_value;
            end else if (dec && (count != 4'd0)) begin
                count <= count - 4'd1;
            end
        end
    end

    assign zero = (count == 4'd0);

endmodule

// File: rtl/tristate_bus_reader.sv
// Consumer end of the shared tri-state register bus.
// Accepts single or burst read requests, selects one source at a time with
// an active-low chip select, waits for the bus to settle, captures it and
// hands each value out over a valid/ready response channel.
module tristate_bus_reader
    import tristate_bus_reader_pkg::*;
#(
    parameter int NrOfBits    = 32,
    parameter int NrOfSources = 4,
    parameter int AddrBits    = 2,
    parameter int SettleTicks = 1
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   ClockEnable,
    input  logic                   Tick,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [AddrBits-1:0]    req_addr,
    input  logic                   req_burst,
    input  logic [NrOfBits-1:0]    bus_in,
    output logic [NrOfSources-1:0] cs,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [NrOfBits-1:0]    rsp_data,
    output logic [AddrBits-1:0]    rsp_addr,
    output logic                   rsp_last,
    output logic                   rsp_err,
    output logic                   busy
);

    localparam logic [NrOfSources-1:0] CS_ALL_HIGH   = NrOfSources'(CS_IDLE);
    localparam logic [AddrBits-1:0]    LAST_ADDR     = AddrBits'(NrOfSources - 1);
    localparam logic [31:0]            SOURCE_COUNT  = 32'(NrOfSources);
    localparam logic [3:0]             SETTLE_RELOAD = 4'(SettleTicks);

    state_t                 state;
    state_t                 state_next;
    logic [AddrBits-1:0]    addr_q;
    logic [AddrBits-1:0]    addr_next;
    logic                   burst_q;
    logic                   burst_next;
    logic [NrOfSources-1:0] cs_next;
    logic                   rsp_valid_next;
    logic [NrOfBits-1:0]    rsp_data_next;
    logic [AddrBits-1:0]    rsp_addr_next;
    logic                   rsp_last_next;
    logic                   rsp_err_next;

    logic                   adv;
    logic                   req_in_range;
    logic [AddrBits-1:0]    addr_inc;
    logic [NrOfSources-1:0] req_cs;
    logic [NrOfSources-1:0] inc_cs;
    logic                   settle_load;
    logic                   settle_dec;
    logic                   settle_zero;

    assign adv          = ClockEnable & Tick;
    assign req_ready    = (state == IDLE) && !Reset;
    assign busy         = (state != IDLE);
    assign req_in_range = (32'(req_addr) < SOURCE_COUNT);
    assign addr_inc     = addr_q + AddrBits'(1);
    assign req_cs       = NrOfSources'(cs_one_hot_low(4'(req_addr)));
    assign inc_cs       = NrOfSources'(cs_one_hot_low(4'(addr_inc)));

    settle_tick_counter u_settle (
        .Clock      (Clock),
        .Reset      (Reset),
        .adv        (adv),
        .load       (settle_load),
        .dec        (settle_dec),
        .load_value (SETTLE_RELOAD),
        .zero       (settle_zero)
    );

    // Next-state and next-output decode; nothing moves without a qualified tick.
    always_comb begin
        state_next     = state;
        addr_next      = addr_q;
        burst_next     = burst_q;
        cs_next        = cs;
        rsp_valid_next = rsp_valid;
        rsp_data_next  = rsp_data;
        rsp_addr_next  = rsp_addr;
        rsp_last_next  = rsp_last;
        rsp_err_next   = rsp_err;
        settle_load    = 1'b0;
        settle_dec     = 1'b0;

        if (adv) begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_next    = req_addr;
                        burst_next   = req_burst;
                        rsp_err_next = 1'b0;
                        if (req_in_range) begin
                            state_next  = SELECT;
                            cs_next     = req_cs;
                            settle_load = 1'b1;
                        end else begin
                            state_next     = RESPOND;
                            rsp_valid_next = 1'b1;
                            rsp_data_next  = '0;
                            rsp_addr_next  = req_addr;
                            rsp_last_next  = 1'b1;
                            rsp_err_next   = 1'b1;
                        end
                    end
                end

                SELECT: begin
                    if (settle_zero) begin
                        rsp_data_next  = bus_in;
                        rsp_addr_next  = addr_q;
                        rsp_last_next  = !burst_q || (addr_q == LAST_ADDR);
                        rsp_valid_next = 1'b1;
                        cs_next        = CS_ALL_HIGH;
                        state_next     = RESPOND;
                    end else begin
                        settle_dec = 1'b1;
                    end
                end

                RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid_next = 1'b0;
                        if (rsp_last) begin
                            state_next = IDLE;
                        end else begin
                            addr_next   = addr_inc;
                            cs_next     = inc_cs;
                            settle_load = 1'b1;
                            state_next  = SELECT;
                        end
                    end
                end

                default: begin
                    state_next     = IDLE;
                    cs_next        = CS_ALL_HIGH;
                    rsp_valid_next = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset releases every chip select at once.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            burst_q   <= 1'b0;
            cs        <= CS_ALL_HIGH;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_addr  <= '0;
            rsp_last  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_next;
            addr_q    <= addr_next;
            burst_q   <= burst_next;
            cs        <= cs_next;
            rsp_valid <= rsp_valid_next;
            rsp_data  <= rsp_data_next;
            rsp_addr  <= rsp_addr_next;
            rsp_last  <= rsp_last_next;
            rsp_err   <= rsp_err_next;
        end
    end

endmodule

// File: tb/tb_tristate_bus_reader.sv
// Self-checking bench for the tri-state bus reader: a main reader with a
// 3-bit address (to reach out-of-range indices) and a second reader with a
// longer settle time driven by a slow tick.
module tb_tristate_bus_reader;

    localparam int NB  = 32;
    localparam int NS  = 4;
    localparam int AB  = 3;
    localparam int AB2 = 2;

    typedef struct packed {
        logic [NB-1:0] data;
        logic [AB-1:0] addr;
        logic          last;
        logic          err;
    } beat_t;

    beat_t expected_q[$];

    int comparisons = 0;
    int failures    = 0;

    logic clock = 1'b0;
    logic reset;
    logic clock_enable;
    logic tick;
    logic tick2;

    logic [NB-1:0] src_val [NS];

    logic          req_valid;
    logic          req_ready;
    logic [AB-1:0] req_addr;
    logic          req_burst;
    logic [NB-1:0] bus;
    logic [NS-1:0] cs;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [NB-1:0] rsp_data;
    logic [AB-1:0] rsp_addr;
    logic          rsp_last;
    logic          rsp_err;
    logic          busy;

    logic           req_valid2;
    logic           req_ready2;
    logic [AB2-1:0] req_addr2;
    logic           req_burst2;
    logic [NB-1:0]  bus2;
    logic [NS-1:0]  cs2;
    logic           rsp_valid2;
    logic           rsp_ready2;
    logic [NB-1:0]  rsp_data2;
    logic [AB2-1:0] rsp_addr2;
    logic           rsp_last2;
    logic           rsp_err2;
    logic           busy2;

    tristate_bus_reader #(
        .NrOfBits(NB), .NrOfSources(NS), .AddrBits(AB), .SettleTicks(1)
    ) dut (
        .Clock(clock), .Reset(reset), .ClockEnable(clock_enable), .Tick(tick),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_burst(req_burst), .bus_in(bus), .cs(cs), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
        .rsp_last(rsp_last), .rsp_err(rsp_err), .busy(busy)
    );

    tristate_bus_reader #(
        .NrOfBits(NB), .NrOfSources(NS), .AddrBits(AB2), .SettleTicks(2)
    ) dut_slow (
        .Clock(clock), .Reset(reset), .ClockEnable(clock_enable), .Tick(tick2),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_addr(req_addr2),
        .req_burst(req_burst2), .bus_in(bus2), .cs(cs2), .rsp_valid(rsp_valid2),
        .rsp_ready(rsp_ready2), .rsp_data(rsp_data2), .rsp_addr(rsp_addr2),
        .rsp_last(rsp_last2), .rsp_err(rsp_err2), .busy(busy2)
    );

    always #5 clock = ~clock;

    // Register sources: each drives its value only while its select is low.
    always_comb begin
        bus = '0;
        for (int i = 0; i < NS; i++) begin
            if (!cs[i]) bus = src_val[i];
        end
    end

    // Same source model for the slow reader's bus.
    always_comb begin
        bus2 = '0;
        for (int i = 0; i < NS; i++) begin
            if (!cs2[i]) bus2 = src_val[i];
        end
    end

    task automatic check_value(input string tag, input logic [NB-1:0] observed,
                               input logic [NB-1:0] expected);
        comparisons++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // At most one source may ever drive the shared bus.
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            check_value("cs_one_hot_low", NB'($countones(~cs) <= 1), 1);
            check_value("cs2_one_hot_low", NB'($countones(~cs2) <= 1), 1);
        end
    end

    // Present one request for one accepting edge and queue the beats it should produce.
    task automatic apply_stimulus(input int addr, input logic burst);
        beat_t b;
        @(negedge clock);
        check_value("req_ready_idle", NB'(req_ready), 1);
        req_valid = 1'b1;
        req_addr  = AB'(addr);
        req_burst = burst;
        if (addr < NS) begin
            for (int i = addr; i < NS; i++) begin
                b.data = src_val[i];
                b.addr = AB'(i);
                b.last = !burst || (i == NS - 1);
                b.err  = 1'b0;
                expected_q.push_back(b);
                if (!burst) break;
            end
        end else begin
            b.data = '0;
            b.addr = AB'(addr);
            b.last = 1'b1;
            b.err  = 1'b1;
            expected_q.push_back(b);
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    // Wait for one response beat, compare it with the scoreboard, optionally stall, then take it.
    task automatic check_output(input int stall);
        beat_t exp_beat;
        int    waited;
        waited = 0;
        while (rsp_valid !== 1'b1 && waited < 50) begin
            @(posedge clock);
            #1;
            waited++;
        end
        check_value("rsp_valid_arrives", NB'(rsp_valid), 1);
        check_value("scoreboard_nonempty", NB'(expected_q.size() != 0), 1);
        if (expected_q.size() != 0) begin
            exp_beat = expected_q.pop_front();
            check_value("rsp_data", rsp_data, exp_beat.data);
            if (!exp_beat.err) check_value("rsp_addr", NB'(rsp_addr), NB'(exp_beat.addr));
            check_value("rsp_last", NB'(rsp_last), NB'(exp_beat.last));
            check_value("rsp_err", NB'(rsp_err), NB'(exp_beat.err));
            check_value("cs_released", NB'(cs), 32'hF);
            for (int k = 0; k < stall; k++) begin
                @(posedge clock);
                #1;
                check_value("stall_valid", NB'(rsp_valid), 1);
                check_value("stall_data", rsp_data, exp_beat.data);
                check_value("stall_last", NB'(rsp_last), NB'(exp_beat.last));
                check_value("stall_cs", NB'(cs), 32'hF);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        rsp_ready = 1'b0;
        check_value("rsp_valid_dropped", NB'(rsp_valid), 0);
    endtask

    initial begin
        int    k;
        logic  accepted;
        logic  done;
        logic [NS-1:0] prev_cs2;
        logic          prev_valid2;

        reset        = 1'b0;
        clock_enable = 1'b1;
        tick         = 1'b1;
        tick2        = 1'b0;
        req_valid    = 1'b0;
        req_addr     = '0;
        req_burst    = 1'b0;
        rsp_ready    = 1'b0;
        req_valid2   = 1'b0;
        req_addr2    = '0;
        req_burst2   = 1'b0;
        rsp_ready2   = 1'b0;
        src_val[0]   = 32'h0A0A0A0A;
        src_val[1]   = 32'h00000011;
        src_val[2]   = 32'hDEADBEEF;
        src_val[3]   = 32'h00000033;
        #1 reset = 1'b1;

        // Reset values
        #11;
        check_value("reset_cs", NB'(cs), 32'hF);
        check_value("reset_rsp_valid", NB'(rsp_valid), 0);
        check_value("reset_rsp_data", rsp_data, 0);
        check_value("reset_rsp_addr", NB'(rsp_addr), 0);
        check_value("reset_rsp_last", NB'(rsp_last), 0);
        check_value("reset_rsp_err", NB'(rsp_err), 0);
        check_value("reset_busy", NB'(busy), 0);
        check_value("reset_req_ready", NB'(req_ready), 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_value("post_reset_req_ready", NB'(req_ready), 1);

        // Single read of source 2 with exact latency
        $display("[TB] single read");
        apply_stimulus(2, 1'b0);
        check_value("single_cs_edge0", NB'(cs), 32'hB);
        check_value("single_busy", NB'(busy), 1);
        @(posedge clock); #1;
        check_value("single_cs_edge1", NB'(cs), 32'hB);
        check_value("single_valid_edge1", NB'(rsp_valid), 0);
        @(posedge clock); #1;
        check_value("single_valid_edge2", NB'(rsp_valid), 1);
        check_value("single_cs_edge2", NB'(cs), 32'hF);
        check_output(0);

        // ClockEnable low freezes the reader mid-select
        $display("[TB] clock enable freeze");
        apply_stimulus(0, 1'b0);
        clock_enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            check_value("freeze_cs", NB'(cs), 32'hE);
            check_value("freeze_valid", NB'(rsp_valid), 0);
            check_value("freeze_busy", NB'(busy), 1);
        end
        clock_enable = 1'b1;
        @(posedge clock); #1;
        check_value("unfreeze_cs_edge1", NB'(cs), 32'hE);
        @(posedge clock); #1;
        check_value("unfreeze_valid_edge2", NB'(rsp_valid), 1);
        check_output(0);

        // Out-of-range address
        $display("[TB] out of range");
        apply_stimulus(5, 1'b0);
        check_value("err_cs_never_low", NB'(cs), 32'hF);
        check_value("err_valid_next_adv", NB'(rsp_valid), 1);
        check_output(0);

        // Burst from source 1 with a stalled first beat and an ignored request while busy
        $display("[TB] burst");
        src_val[2] = 32'h00000022;
        apply_stimulus(1, 1'b1);
        req_valid = 1'b1;
        req_addr  = '0;
        req_burst = 1'b0;
        check_value("busy_req_ready", NB'(req_ready), 0);
        check_output(5);
        req_valid = 1'b0;
        check_output(0);
        check_output(0);

        // Response ready early, burst starting at the last source
        $display("[TB] burst at last source");
        rsp_ready = 1'b1;
        apply_stimulus(3, 1'b1);
        check_output(0);

        // Reset in the middle of a burst
        $display("[TB] reset mid burst");
        apply_stimulus(1, 1'b1);
        check_value("pre_reset_cs", NB'(cs), 32'hD);
        #1 reset = 1'b1;
        #1;
        check_value("async_reset_cs", NB'(cs), 32'hF);
        check_value("async_reset_valid", NB'(rsp_valid), 0);
        check_value("async_reset_busy", NB'(busy), 0);
        check_value("async_reset_req_ready", NB'(req_ready), 0);
        expected_q.delete();
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_value("rearm_req_ready", NB'(req_ready), 1);
        apply_stimulus(2, 1'b0);
        check_output(0);

        // Slow tick with a longer settle time on the second reader
        $display("[TB] slow tick");
        req_valid2  = 1'b1;
        req_addr2   = 2'd2;
        accepted    = 1'b0;
        done        = 1'b0;
        k           = 0;
        prev_cs2    = cs2;
        prev_valid2 = rsp_valid2;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clock);
            tick2 = (c % 3 == 2);
            @(posedge clock); #1;
            if (tick2) begin
                if (!accepted) begin
                    accepted   = 1'b1;
                    k          = 0;
                    req_valid2 = 1'b0;
                end else begin
                    k++;
                end
                if (k <= 2) begin
                    check_value("slow_cs_low", NB'(cs2), 32'hB);
                    check_value("slow_valid_low", NB'(rsp_valid2), 0);
                end else if (k == 3) begin
                    check_value("slow_cs_released", NB'(cs2), 32'hF);
                    check_value("slow_valid", NB'(rsp_valid2), 1);
                    check_value("slow_data", rsp_data2, src_val[2]);
                    check_value("slow_last", NB'(rsp_last2), 1);
                    check_value("slow_err", NB'(rsp_err2), 0);
                    check_value("slow_addr", NB'(rsp_addr2), 2);
                    rsp_ready2 = 1'b1;
                end else begin
                    check_value("slow_valid_taken", NB'(rsp_valid2), 0);
                    check_value("slow_busy_done", NB'(busy2), 0);
                    rsp_ready2 = 1'b0;
                    done       = 1'b1;
                end
            end else begin
                check_value("slow_hold_cs", NB'(cs2), NB'(prev_cs2));
                check_value("slow_hold_valid", NB'(rsp_valid2), NB'(prev_valid2));
            end
            prev_cs2    = cs2;
            prev_valid2 = rsp_valid2;
        end
        tick2 = 1'b0;
        check_value("slow_test_completed", NB'(done), 1);

        check_value("scoreboard_drained", NB'(expected_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", comparisons, failures);
        $finish;
    end

endmodule

// File: doc/tristate_bus_reader.md
Name: tristate_bus_reader

Overview:
- Bus-side reader for the shared tri-state register bus.
- Many output-enabled pipeline/holding registers share one NrOfBits bus. Each register drives the bus only while its cs is low; cs high floats it to Z.
- This block is the consumer end. It accepts read requests, drives exactly one cs line low, waits for the bus to settle, captures the value and returns it over a valid/ready response channel.
- Burst mode sweeps consecutive sources for debug and snapshot of pipeline state.

Parameters:
- NrOfBits, 32, width of the shared data bus and response data.
- NrOfSources, 4, number of tri-state sources (cs lines). Range 2..16.
- AddrBits, 2, width of req_addr/rsp_addr. Must be at least ceil(log2(NrOfSources)).
- SettleTicks, 1, qualified ticks cs is held low before capture. Range 1..15.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- ClockEnable  in  1  global enable; state advances only when ClockEnable&Tick.
- Tick  in  1  tick qualifier; together with ClockEnable forms the advance condition "adv".
- req_valid  in  1  read request present.
- req_ready  out  1  block can accept a request.
- req_addr  in  AddrBits  index of the first source to read.
- req_burst  in  1  1 = read req_addr through NrOfSources-1; 0 = single read.
- bus_in  in  NrOfBits  shared tri-state bus.
- cs  out  NrOfSources  per-source select, active-low drive enable; 1 = source floats.
- rsp_valid  out  1  response data valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  NrOfBits  captured bus value.
- rsp_addr  out  AddrBits  source index of this response.
- rsp_last  out  1  final beat of the request.
- rsp_err  out  1  address out of range; rsp_data forced to 0.
- busy  out  1  state != IDLE.

Behaviour:
- Reset is asynchronous and active-high; clock is Clock.
- While Reset is asserted:
  - state = IDLE.
  - cs = all ones, asynchronously. No source may be left driving.
  - rsp_valid = 0, rsp_data = 0, rsp_addr = 0, rsp_last = 0, rsp_err = 0.
  - busy = 0, req_ready = 0.
- All flops are posedge Clock. Every state change and handshake completes only on an edge with adv = ClockEnable&Tick.
- req_ready = (state == IDLE) && !Reset. A request is accepted on adv && req_valid && req_ready.
- States:
  - IDLE: on accept, latch addr and burst flag.
    - If addr < NrOfSources: go to SELECT, set cs[addr] = 0 (registered), load settle count = SettleTicks.
    - Otherwise: go to RESPOND with rsp_err = 1, rsp_data = 0, rsp_last = 1. No cs asserted.
  - SELECT: cs[addr] = 0 and all other cs bits = 1, one-hot-low at all times. Count decrements on adv.
    - When the count reaches 0 on adv: capture bus_in into rsp_data, set rsp_addr = addr.
    - Set rsp_last = (!burst || addr == NrOfSources-1).
    - Set rsp_valid = 1, cs = all ones, go to RESPOND.
  - RESPOND: rsp_valid, rsp_data, rsp_addr, rsp_last and rsp_err hold stable until adv && rsp_ready.
    - On that edge, clear rsp_valid.
    - If rsp_last: go to IDLE.
    - Else: addr = addr+1, go to SELECT, cs[addr+1] = 0, reload the settle count.
- Latency for a single read, counted in adv edges:
  - Accept at edge 0.
  - cs low from edge 0 through edge SettleTicks.
  - rsp_valid high after edge SettleTicks+1.
- Boundary conditions:
  - Capture samples bus_in at the edge ending SELECT. cs is released on that same edge, so no gap exists with multiple drivers.
  - Burst starting at NrOfSources-1 is a single beat with rsp_last = 1.
  - Address wrap-around never occurs; a burst stops at the last source.
  - rsp_ready high before rsp_valid has no effect.
  - req_valid held during busy is ignored (no queueing).
  - ClockEnable=0 or Tick=0 freezes all state, counters and outputs, including cs.
  - Reset mid-burst aborts immediately. Remaining beats are discarded and the pending response is dropped.
- rsp_err is cleared on the first request after reset or on any new accepted valid request.

Decomposition:
- Shared package contents:
  - state encoding: IDLE=2'd0, SELECT=2'd1, RESPOND=2'd2.
  - constant CS_IDLE = all ones.
  - helper function for one-hot-low cs generation from index.
- Sub-module: settle_tick_counter.
  - 4-bit down-counter with load, adv and zero flag.
  - Async Reset to 0.

Test Plan:
- NrOfBits=32, NrOfSources=4, SettleTicks=1, Tick=ClockEnable=1. Source 2 drives 0xDEADBEEF when cs[2]=0. Single read of addr 2 -> cs=4'b1011 for 2 edges, then rsp_valid=1, rsp_data=0xDEADBEEF, rsp_addr=2, rsp_last=1, rsp_err=0, cs=4'b1111.
- Burst from addr 1; sources 1..3 drive 0x11, 0x22, 0x33 -> three beats with rsp_addr 1,2,3, data 0x11/0x22/0x33, rsp_last only on beat 3. Never more than one cs bit low.
- rsp_ready held 0 for 5 edges on beat 1 -> rsp_* stable, cs=4'b1111 throughout; beat 2 starts only after the ready edge.
- With AddrBits=3, req_addr=5 -> no cs bit ever low; rsp_valid next adv with rsp_err=1, rsp_data=0, rsp_last=1.
- Tick pulsed every 3rd clock with SettleTicks=2 -> cs low exactly 3 tick-edges. Capture happens at the 3rd tick-edge; nothing advances between ticks.
- Reset asserted while cs=4'b1101 in SELECT mid-burst -> cs=4'b1111 within the same cycle (async), rsp_valid=0, busy=0. After release, req_ready=1 and a new request works normally.
